// File: rtl/axi_xbar_pkg.sv
// Shared write-path crossbar definitions: master tags, slave address map,
// slave/state enums and the address decoder.
package axi_xbar_pkg;

    localparam logic [3:0] TAG_M1  = 4'b0010;
    localparam logic [3:0] TAG_M2  = 4'b0100;
    localparam int         NUM_SLV = 6;

    localparam logic [31:0] S0_BASE = 32'h0000_0000, S0_LIMIT = 32'h0000_1FFF;
    localparam logic [31:0] S1_BASE = 32'h0001_0000, S1_LIMIT = 32'h0001_FFFF;
    localparam logic [31:0] S2_BASE = 32'h0002_0000, S2_LIMIT = 32'h0002_FFFF;
    localparam logic [31:0] S3_BASE = 32'h1002_0000, S3_LIMIT = 32'h1002_03FF;
    localparam logic [31:0] S4_BASE = 32'h1001_0000, S4_LIMIT = 32'h1001_03FF;
    localparam logic [31:0] S5_BASE = 32'h2000_0000, S5_LIMIT = 32'h201F_FFFF;

    typedef enum logic [2:0] {
        SLV_ROM  = 3'd0,
        SLV_IM   = 3'd1,
        SLV_DM   = 3'd2,
        SLV_DMA  = 3'd3,
        SLV_WDT  = 3'd4,
        SLV_DRAM = 3'd5
    } slv_idx_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_DATA = 2'd2
    } aw_state_e;

    typedef struct packed {
        logic     mapped;
        slv_idx_e idx;
    } dec_res_t;

    // Offset compare wraps below base, so one unsigned test covers both ends.
    function automatic logic in_range(input logic [31:0] addr,
                                      input logic [31:0] base,
                                      input logic [31:0] limit);
        return (addr - base) <= (limit - base);
    endfunction

    function automatic dec_res_t decode_addr(input logic [31:0] addr);
        dec_res_t res;
        res.mapped = 1'b1;
        res.idx    = SLV_ROM;
        if (in_range(addr, S0_BASE, S0_LIMIT))      res.idx = SLV_ROM;
        else if (in_range(addr, S1_BASE, S1_LIMIT)) res.idx = SLV_IM;
        else if (in_range(addr, S2_BASE, S2_LIMIT)) res.idx = SLV_DM;
        else if (in_range(addr, S3_BASE, S3_LIMIT)) res.idx = SLV_DMA;
        else if (in_range(addr, S4_BASE, S4_LIMIT)) res.idx = SLV_WDT;
        else if (in_range(addr, S5_BASE, S5_LIMIT)) res.idx = SLV_DRAM;
        else                                        res.mapped = 1'b0;
        return res;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter. The pointer only moves on upd, pointing
// away from the requester named by last_idx.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       upd,
    input  logic       last_idx,
    output logic [1:0] gnt,
    output logic       gnt_idx
);

    logic ptr_q;  // 0 favours req[0], 1 favours req[1]

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)     ptr_q <= 1'b0;
        else if (upd) ptr_q <= ~last_idx;
    end

    always_comb begin
        gnt_idx = 1'b0;
        gnt     = 2'b00;
        if (req[1] && (!req[0] || ptr_q)) gnt_idx = 1'b1;
        if (gnt_idx)     gnt = 2'b10;
        else if (req[0]) gnt = 2'b01;
    end

endmodule

// File: rtl/write_addr_arbiter.sv
// AW-channel arbiter for masters M1/M2: grants one request, decodes it to one of
// six slaves, presents it, then holds the bus until the write burst finishes.
module write_addr_arbiter
    import axi_xbar_pkg::*;
#(
    parameter int ID_W   = 4,
    parameter int IDS_W  = 8,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ID_W-1:0]   AWID_M1,
    input  logic [ADDR_W-1:0] AWADDR_M1,
    input  logic [3:0]        AWLEN_M1,
    input  logic [2:0]        AWSIZE_M1,
    input  logic [1:0]        AWBURST_M1,
    input  logic              AWVALID_M1,
    output logic              AWREADY_M1,
    input  logic [ID_W-1:0]   AWID_M2,
    input  logic [ADDR_W-1:0] AWADDR_M2,
    input  logic [3:0]        AWLEN_M2,
    input  logic [2:0]        AWSIZE_M2,
    input  logic [1:0]        AWBURST_M2,
    input  logic              AWVALID_M2,
    output logic              AWREADY_M2,
    output logic [IDS_W-1:0]  AWID_S0, AWID_S1, AWID_S2, AWID_S3, AWID_S4, AWID_S5,
    output logic [ADDR_W-1:0] AWADDR_S0, AWADDR_S1, AWADDR_S2, AWADDR_S3, AWADDR_S4, AWADDR_S5,
    output logic [3:0]        AWLEN_S0, AWLEN_S1, AWLEN_S2, AWLEN_S3, AWLEN_S4, AWLEN_S5,
    output logic [2:0]        AWSIZE_S0, AWSIZE_S1, AWSIZE_S2, AWSIZE_S3, AWSIZE_S4, AWSIZE_S5,
    output logic [1:0]        AWBURST_S0, AWBURST_S1, AWBURST_S2, AWBURST_S3, AWBURST_S4, AWBURST_S5,
    output logic              AWVALID_S0, AWVALID_S1, AWVALID_S2, AWVALID_S3, AWVALID_S4, AWVALID_S5,
    input  logic              AWREADY_S0, AWREADY_S1, AWREADY_S2, AWREADY_S3, AWREADY_S4, AWREADY_S5,
    input  logic              w_last_hs,
    output logic              decerr
);

    // state   | meaning
    // IDLE    | no write outstanding; arbitrate and accept one master request
    // SEND    | AWVALID raised on the decoded slave, waiting for its AWREADY
    // DATA    | address delivered (or unmapped); wait for the last W beat

    aw_state_e           state_q, state_d;
    logic [IDS_W-1:0]    id_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [3:0]          len_q;
    logic [2:0]          size_q;
    logic [1:0]          burst_q;
    slv_idx_e            slv_q;
    logic                decerr_q;
    logic                gnt_idx_q;

    logic [1:0]          req, gnt;
    logic                gnt_idx;
    logic                capture, done;
    logic [NUM_SLV-1:0]  slv_ready, slv_valid;
    logic [ADDR_W-1:0]   addr_mux;
    logic [IDS_W-1:0]    id_mux;
    dec_res_t            dec;

    assign req       = {AWVALID_M2, AWVALID_M1};
    assign slv_ready = {AWREADY_S5, AWREADY_S4, AWREADY_S3, AWREADY_S2, AWREADY_S1, AWREADY_S0};

    rr_arb2 u_arb (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .upd      (done),
        .last_idx (gnt_idx_q),
        .gnt      (gnt),
        .gnt_idx  (gnt_idx)
    );

    assign addr_mux = gnt_idx ? AWADDR_M2 : AWADDR_M1;
    assign id_mux   = gnt_idx ? IDS_W'({TAG_M2, AWID_M2}) : IDS_W'({TAG_M1, AWID_M1});
    assign dec      = decode_addr(32'(addr_mux));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= ST_IDLE;
        else      state_q <= state_d;
    end

    // AWREADY is gated by rst so a master holding AWVALID during reset sees no accept.
    always_comb begin
        state_d    = state_q;
        capture    = 1'b0;
        done       = 1'b0;
        slv_valid  = '0;
        AWREADY_M1 = 1'b0;
        AWREADY_M2 = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (rst && (|req)) begin
                    capture    = 1'b1;
                    AWREADY_M1 = gnt[0];
                    AWREADY_M2 = gnt[1];
                    state_d    = dec.mapped ? ST_SEND : ST_DATA;
                end
            end
            ST_SEND: begin
                slv_valid[slv_q] = 1'b1;
                if (slv_ready[slv_q]) state_d = ST_DATA;
            end
            ST_DATA: begin
                if (w_last_hs) begin
                    done    = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            id_q      <= '0;
            addr_q    <= '0;
            len_q     <= '0;
            size_q    <= '0;
            burst_q   <= '0;
            slv_q     <= SLV_ROM;
            decerr_q  <= 1'b0;
            gnt_idx_q <= 1'b0;
        end else if (capture) begin
            id_q      <= id_mux;
            addr_q    <= addr_mux;
            len_q     <= gnt_idx ? AWLEN_M2   : AWLEN_M1;
            size_q    <= gnt_idx ? AWSIZE_M2  : AWSIZE_M1;
            burst_q   <= gnt_idx ? AWBURST_M2 : AWBURST_M1;
            slv_q     <= dec.idx;
            decerr_q  <= ~dec.mapped;
            gnt_idx_q <= gnt_idx;
        end else if (done) begin
            decerr_q  <= 1'b0;
        end
    end

    assign decerr = decerr_q;

    assign {AWVALID_S5, AWVALID_S4, AWVALID_S3, AWVALID_S2, AWVALID_S1, AWVALID_S0} = slv_valid;

    assign AWID_S0 = id_q;  assign AWADDR_S0 = addr_q;  assign AWLEN_S0 = len_q;
    assign AWID_S1 = id_q;  assign AWADDR_S1 = addr_q;  assign AWLEN_S1 = len_q;
    assign AWID_S2 = id_q;  assign AWADDR_S2 = addr_q;  assign AWLEN_S2 = len_q;
    assign AWID_S3 = id_q;  assign AWADDR_S3 = addr_q;  assign AWLEN_S3 = len_q;
    assign AWID_S4 = id_q;  assign AWADDR_S4 = addr_q;  assign AWLEN_S4 = len_q;
    assign AWID_S5 = id_q;  assign AWADDR_S5 = addr_q;  assign AWLEN_S5 = len_q;

    assign AWSIZE_S0 = size_q;  assign AWBURST_S0 = burst_q;
    assign AWSIZE_S1 = size_q;  assign AWBURST_S1 = burst_q;
    assign AWSIZE_S2 = size_q;  assign AWBURST_S2 = burst_q;
    assign AWSIZE_S3 = size_q;  assign AWBURST_S3 = burst_q;
    assign AWSIZE_S4 = size_q;  assign AWBURST_S4 = burst_q;
    assign AWSIZE_S5 = size_q;  assign AWBURST_S5 = burst_q;

endmodule
